// File: rtl/snake_input_conditioner_pkg.sv
// Shared definitions for the snake input conditioner.
// Contents:
//   dir_e         - heading encoding handed to the game core (UP/DOWN/LEFT/RIGHT)
//   BTN_*         - bit positions of the buttons on the SW bus
//   opposite_dir  - heading pointing the other way (used by the reversal rule)
package snake_input_conditioner_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_PAUSE = 4;

  function automatic dir_e opposite_dir(input dir_e d);
    case (d)
      DIR_UP:   opposite_dir = DIR_DOWN;
      DIR_DOWN: opposite_dir = DIR_UP;
      DIR_LEFT: opposite_dir = DIR_RIGHT;
      default:  opposite_dir = DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_input_conditioner_sw_debounce.sv
// Single-button front end: 2-flop synchroniser followed by a debounce counter.
// The debounced level only follows the synchronised input after it has
// differed from the current level for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   sw_in   - raw asynchronous button level
//   db_out  - debounced level
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic db_out
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= sw_in;
      r_sync2 <= r_sync1;
      // Any cycle agreeing with the accepted level restarts the count, so a
      // glitch shorter than DEBOUNCE_CYCLES never reaches the output.
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST_CNT) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign db_out = r_db;

endmodule

// File: rtl/snake_input_conditioner.sv
// Input conditioner in front of the snake game core.
// Debounces the five buttons, produces one-cycle press pulses, tracks the
// requested heading (no reversal, no repeat) and the pause state, and only
// commits a new heading on a game-step strobe while not paused.
// Ports:
//   CLK1_50  - 50 MHz system clock
//   RESET    - synchronous active-high reset
//   SW[4:0]  - raw buttons: up, down, left, right, pause
//   step     - one-cycle game-step strobe
//   sw_db    - debounced button levels
//   press    - one-cycle pulse per debounced rising edge
//   dir      - committed heading (0=UP 1=DOWN 2=LEFT 3=RIGHT)
//   dir_chg  - one-cycle pulse when dir changes
//   paused   - pause state
module snake_input_conditioner
  import snake_input_conditioner_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         CNT_W           = 19,
  parameter logic [1:0] RESET_DIR       = 2'd3
) (
  input  logic       CLK1_50,
  input  logic       RESET,
  input  logic [4:0] SW,
  input  logic       step,
  output logic [4:0] sw_db,
  output logic [4:0] press,
  output logic [1:0] dir,
  output logic       dir_chg,
  output logic       paused
);

  logic [4:0] w_sw_db;
  logic [4:0] r_db_d;
  logic [4:0] r_press;
  dir_e       r_dir;
  dir_e       r_pending;
  logic       r_pend_v;
  logic       r_dir_chg;
  logic       r_paused;

  dir_e       w_cand;
  logic       w_cand_v;
  logic       w_accept;
  logic       w_commit;
  dir_e       w_nxt_dir;
  dir_e       w_nxt_pending;
  logic       w_nxt_pend_v;
  logic       w_nxt_chg;

  // Stage 0: per-button synchronise and debounce
  for (genvar gi = 0; gi < 5; gi++) begin : g_btn
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk   (CLK1_50),
      .rst   (RESET),
      .sw_in (SW[gi]),
      .db_out(w_sw_db[gi])
    );
  end

  // Stage 1: rising-edge detect on the debounced levels
  always_ff @(posedge CLK1_50) begin
    if (RESET) begin
      r_db_d  <= '0;
      r_press <= '0;
    end else begin
      r_db_d  <= w_sw_db;
      r_press <= w_sw_db & ~r_db_d;
    end
  end

  // Stage 2: heading request, commit on step, pause toggle
  always_comb begin
    w_cand = DIR_RIGHT;
    if (r_press[BTN_UP])        w_cand = DIR_UP;
    else if (r_press[BTN_DOWN]) w_cand = DIR_DOWN;
    else if (r_press[BTN_LEFT]) w_cand = DIR_LEFT;
  end

  assign w_cand_v = |r_press[BTN_RIGHT:BTN_UP];
  assign w_accept = w_cand_v && (w_cand != r_dir) && (w_cand != opposite_dir(r_dir));
  // Step is judged against the paused value before any same-cycle toggle.
  assign w_commit = step && !r_paused;

  always_comb begin
    w_nxt_dir     = r_dir;
    w_nxt_pending = r_pending;
    w_nxt_pend_v  = r_pend_v;
    w_nxt_chg     = 1'b0;
    if (w_accept) begin
      w_nxt_pending = w_cand;
      w_nxt_pend_v  = 1'b1;
    end
    // A same-cycle accepted press bypasses pending; otherwise the stored
    // request (if any) is committed.
    if (w_commit) begin
      if (w_accept) begin
        w_nxt_dir    = w_cand;
        w_nxt_pend_v = 1'b0;
        w_nxt_chg    = 1'b1;
      end else if (r_pend_v) begin
        w_nxt_dir    = r_pending;
        w_nxt_pend_v = 1'b0;
        w_nxt_chg    = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK1_50) begin
    if (RESET) begin
      r_dir     <= dir_e'(RESET_DIR);
      r_pending <= dir_e'(RESET_DIR);
      r_pend_v  <= 1'b0;
      r_dir_chg <= 1'b0;
      r_paused  <= 1'b0;
    end else begin
      r_dir     <= w_nxt_dir;
      r_pending <= w_nxt_pending;
      r_pend_v  <= w_nxt_pend_v;
      r_dir_chg <= w_nxt_chg;
      r_paused  <= r_paused ^ r_press[BTN_PAUSE];
    end
  end

  assign sw_db   = w_sw_db;
  assign press   = r_press;
  assign dir     = r_dir;
  assign dir_chg = r_dir_chg;
  assign paused  = r_paused;

endmodule
